// File: rtl/uart_pkg.sv
// Shared constants, bit-timing helpers and receiver FSM states for the UART word link.
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
        return freq / baud;
    endfunction

    function automatic int unsigned half_bit(input int unsigned freq, input int unsigned baud);
        return (freq / baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Single 8N1 frame receiver: rx synchronizer, mid-bit sampling FSM and bit timing.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned FREQ      = 12000000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [BYTE_W-1:0] byte_data,
    output logic              byte_strobe_c,
    output logic              frame_err_c,
    output logic              busy
);

    localparam int unsigned LIM   = clks_per_bit(FREQ, BAUD);
    localparam int unsigned HALF  = half_bit(FREQ, BAUD);
    localparam int unsigned CNT_W = $clog2(LIM);

    logic              r_sync1;
    logic              r_sync2;
    logic              w_rxs;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [2:0]        r_bit;
    logic [2:0]        w_bit_nxt;
    logic [BYTE_W-1:0] r_shift;
    logic [BYTE_W-1:0] w_shift_nxt;
    logic [BYTE_W-1:0] w_shift_in;
    logic              r_busy;

    assign w_rxs      = r_sync2;
    assign w_shift_in = (MSB_FIRST != 0) ? {r_shift[BYTE_W-2:0], w_rxs}
                                         : {w_rxs, r_shift[BYTE_W-1:1]};

    // State and datapath registers; busy follows the next state so it matches r_state exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_nxt     = r_bit;
        w_shift_nxt   = r_shift;
        byte_strobe_c = 1'b0;
        frame_err_c   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = '0;
                end
            end
            ST_START: begin
                if (r_cnt == CNT_W'(HALF - 1)) begin
                    w_cnt_nxt = '0;
                    w_bit_nxt = '0;
                    // A start bit that is high again at mid-bit was only a glitch
                    w_state_nxt = w_rxs ? ST_IDLE : ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (r_cnt == CNT_W'(LIM - 1)) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = w_shift_in;
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (r_cnt == CNT_W'(LIM - 1)) begin
                    w_cnt_nxt = '0;
                    if (w_rxs) begin
                        byte_strobe_c = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        frame_err_c = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                if (w_rxs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign byte_data = r_shift;
    assign busy      = r_busy;

endmodule

// File: rtl/uart_word_rx.sv
// Reassembles BYTES received UART frames into one word with valid/ready, overrun and gap timeout.
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int unsigned FREQ      = 12000000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned BYTES     = 4,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned GAP_BITS  = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx,
    output logic [BYTE_W*BYTES-1:0]      word_data,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic [$clog2(BYTES+1)-1:0]   byte_count,
    output logic                         busy,
    output logic                         frame_err,
    output logic                         overrun
);

    localparam int unsigned WORD_W = BYTE_W * BYTES;
    localparam int unsigned PART_W = WORD_W - BYTE_W;
    localparam int unsigned BC_W   = $clog2(BYTES + 1);
    localparam int unsigned LIM    = clks_per_bit(FREQ, BAUD);
    localparam int unsigned CNT_W  = $clog2(LIM);
    localparam int unsigned GAP_W  = $clog2(GAP_BITS + 1);

    logic [BYTE_W-1:0] w_byte;
    logic              w_strobe;
    logic              w_ferr;
    logic              w_busy;
    logic [WORD_W-1:0] w_word;
    logic              w_word_done;
    logic              w_can_load;
    logic              w_gap_run;
    logic              w_gap_tick;
    logic              w_gap_expire;

    logic [PART_W-1:0] r_partial;
    logic [BC_W-1:0]   r_byte_count;
    logic [WORD_W-1:0] r_word_data;
    logic              r_word_valid;
    logic              r_frame_err;
    logic              r_overrun;
    logic [CNT_W-1:0]  r_gap_clk;
    logic [GAP_W-1:0]  r_gap_bits;

    uart_rx_byte #(
        .FREQ      (FREQ),
        .BAUD      (BAUD),
        .MSB_FIRST (MSB_FIRST)
    ) u_rx_byte (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .byte_data     (w_byte),
        .byte_strobe_c (w_strobe),
        .frame_err_c   (w_ferr),
        .busy          (w_busy)
    );

    assign w_word       = {r_partial, w_byte};
    assign w_word_done  = w_strobe && (r_byte_count == BC_W'(BYTES - 1));
    assign w_can_load   = !r_word_valid || word_ready;
    // Gap timer only runs while the line is idle with a partial word pending
    assign w_gap_run    = !w_busy && (r_byte_count != '0);
    assign w_gap_tick   = (r_gap_clk == CNT_W'(LIM - 1));
    assign w_gap_expire = w_gap_run && w_gap_tick && (r_gap_bits == GAP_W'(GAP_BITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_partial    <= '0;
            r_byte_count <= '0;
            r_word_data  <= '0;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_gap_clk    <= '0;
            r_gap_bits   <= '0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= 1'b0;

            if (r_word_valid && word_ready) begin
                r_word_valid <= 1'b0;
            end
            // A completed word either loads (possibly replacing one consumed this cycle) or is dropped
            if (w_word_done) begin
                if (w_can_load) begin
                    r_word_data  <= w_word;
                    r_word_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end

            if (w_strobe) begin
                r_partial    <= w_word_done ? '0 : w_word[PART_W-1:0];
                r_byte_count <= w_word_done ? '0 : r_byte_count + BC_W'(1);
            end else if (w_ferr || w_gap_expire) begin
                r_partial    <= '0;
                r_byte_count <= '0;
            end

            if (w_gap_run && !w_gap_tick) begin
                r_gap_clk <= r_gap_clk + CNT_W'(1);
            end else begin
                r_gap_clk <= '0;
            end
            if (!w_gap_run || w_gap_expire) begin
                r_gap_bits <= '0;
            end else if (w_gap_tick) begin
                r_gap_bits <= r_gap_bits + GAP_W'(1);
            end
        end
    end

    assign word_data  = r_word_data;
    assign word_valid = r_word_valid;
    assign byte_count = r_byte_count;
    assign busy       = w_busy;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

// File: doc/uart_word_rx.md
Name: uart_word_rx

Overview:
Receiving end of the team's 4-byte UART burst link. The link transmitter sends a 32-bit word as BYTES consecutive 8N1 frames, high byte first and MSB-first within each byte. This block recovers each frame with mid-bit sampling, reassembles the bytes into one word, and presents the word on a valid/ready interface. It sits between the rx pin and downstream word-consuming logic, and flags framing and overrun errors.

Parameters:
FREQ, 12000000, system clock frequency in Hz.
BAUD, 9600, line rate in bits per second; LIM = FREQ/BAUD clocks per bit (1250); HALF = LIM/2 (625).
BYTES, 4, number of bytes per word; word width is 8*BYTES.
MSB_FIRST, 1, 1: the first data bit of a frame goes to bit 7; 0: the first data bit goes to bit 0.
GAP_BITS, 20, number of idle bit-times after which a partial word is discarded.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
rx  in  1  asynchronous serial input; idles high.
word_data  out  8*BYTES  assembled word; the first received byte occupies [8*BYTES-1 -: 8].
word_valid  out  1  word_data holds an unconsumed word.
word_ready  in  1  consumer accepts the word on the cycle where word_valid && word_ready.
byte_count  out  $clog2(BYTES+1)  bytes of the current partial word.
busy  out  1  high in every FSM state except IDLE.
frame_err  out  1  one-cycle pulse on a bad stop bit.
overrun  out  1  one-cycle pulse when a completed word is dropped.

Behaviour:
- Interface: one clock, clk. Synchronous, active-high reset, rst. All logic changes state only on posedge clk.
- rx passes through a 2-flop synchronizer (both flops reset to 1); rxs is the synchronizer output. Every use of "rx" below means rxs.
- Reset values: all outputs 0, word_data 0, FSM in IDLE, all counters 0. Reset asserted mid-frame aborts the frame and discards any partial word.
- FSM states:
  - IDLE: rxs==0 moves to START and clears the bit counter cnt.
  - START: when cnt==HALF-1, sample rxs. If rxs==0, go to DATA with cnt=0 and bit index 0. If rxs==1, the start was a glitch; return to IDLE with no error.
  - DATA: when cnt==LIM-1, sample rxs at mid-bit and shift it into the byte per MSB_FIRST. After the 8th sample, go to STOP.
  - STOP: when cnt==LIM-1, sample rxs. If rxs==1, the byte is accepted and the FSM returns to IDLE. If rxs==0, pulse frame_err, drop the byte, clear the partial word and byte_count, and go to BREAK.
  - BREAK: wait for rxs==1, then go to IDLE. No start detection happens while in BREAK.
- Byte accept:
  - partial <= {partial[8*BYTES-9:0], byte} and byte_count increments.
  - On the BYTES-th byte, byte_count returns to 0 and the word completes.
- Word completion:
  - If word_valid==0, or word_valid && word_ready in the same cycle: load word_data and set word_valid=1 on the next cycle. Latency from the last stop-bit sample to word_valid is 1 clock.
  - Otherwise: pulse overrun, drop the new word, and leave word_data and word_valid unchanged.
- Handshake:
  - word_valid stays high until a cycle with word_ready==1; it clears on the next cycle unless a new word loads in that same cycle, in which case it stays 1 with the new data.
  - word_data is stable while word_valid==1.
- Gap timeout: in IDLE with byte_count!=0, a gap counter counts bit-times. When it reaches GAP_BITS, the partial word is cleared and byte_count returns to 0, with no error pulse. Any start detection resets the gap counter.
- Arithmetic: cnt is $clog2(LIM) bits wide and wraps only through the explicit clears above. byte_count never exceeds BYTES-1 as a visible value.

Decomposition:
- Package uart_pkg holds:
  - the LIM/HALF computation function;
  - the FSM state enum (IDLE, START, DATA, STOP, BREAK);
  - the BYTE_W=8 constant.
- Sub-module uart_rx_byte holds the synchronizer, the FSM and the bit timing. It outputs byte, byte_strobe and frame_err.
- The top level (uart_word_rx) holds the word assembler, the gap timer, and the valid/ready/overrun logic.

Test Plan:
- Reset, then send frames 0xDE, 0xAD, 0xBE, 0xEF at 1250 clk/bit with word_ready=1 → word_data=0xDEADBEEF, word_valid high for exactly 1 cycle, 1 clk after the 4th stop sample; frame_err=0 and overrun=0 throughout.
- A 300-clk low glitch on rx while idle → FSM returns to IDLE, byte_count=0, no pulses. A valid word sent afterwards is received correctly.
- Byte 0x12 with the stop bit forced low → frame_err pulses once and byte_count=0. After rx returns high, 0x11223344 is received intact.
- word_ready=0; send 0x01020304 then 0xA0B0C0D0 → word_data stays 0x01020304 and overrun pulses once at the second completion. Asserting word_ready then clears word_valid.
- Send 2 bytes, idle for 21 bit-times, then send 0xCAFEF00D → the partial word is discarded and the output is 0xCAFEF00D.
- Assert rst mid-DATA of the 3rd byte → all outputs 0 and byte_count=0. The next full 4-byte burst is received correctly.
